// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared definitions for the round-robin one-hot arbiter: FSM encoding,
// default sizing and the index-width helper.
package rr_onehot_arbiter_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } arb_state_e;

  localparam int DEFAULT_NUM_REQ  = 16;
  localparam int DEFAULT_MAX_HOLD = 8;

  // Width of a binary index able to address n requesters (at least 1 bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_onehot_arbiter_one_hot.sv
// Binary-to-one-hot encoder; codes at or above ONE_HOT_W produce all zeros.
module rr_onehot_arbiter_one_hot #(
  parameter int BIN_W     = 4,
  parameter int ONE_HOT_W = 16
) (
  input  logic [BIN_W-1:0]     bin_i,
  output logic [ONE_HOT_W-1:0] one_hot_o
);

  genvar gi;
  generate
    for (gi = 0; gi < ONE_HOT_W; gi++) begin : g_bit
      assign one_hot_o[gi] = (bin_i == BIN_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter: registered binary owner index with a hold timer and a
// rotating priority pointer; the one-hot grant is decoded from registers only.
module rr_onehot_arbiter
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = DEFAULT_NUM_REQ,
  parameter int IDX_W    = idx_width(NUM_REQ),
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int HOLD_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               release_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_valid_o,
  output logic               timeout_o
);

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_reg, state_next;
  logic [IDX_W-1:0]   grant_idx_reg, grant_idx_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic               timeout_reg, timeout_next;

  logic [NUM_REQ-1:0] idx_one_hot;
  logic               owner_req;
  logic               hold_expired;
  logic               grant_done;

  // First set bit at or above ptr, otherwise the first set bit below it.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        pick  = IDX_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        pick  = IDX_W'(i);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  rr_onehot_arbiter_one_hot #(
    .BIN_W     (IDX_W),
    .ONE_HOT_W (NUM_REQ)
  ) u_one_hot (
    .bin_i     (grant_idx_reg),
    .one_hot_o (idx_one_hot)
  );

  assign owner_req    = |(req_i & idx_one_hot);
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LAST);
  assign grant_done   = release_i || !owner_req || hold_expired;

  always_comb begin
    state_next     = state_reg;
    grant_idx_next = grant_idx_reg;
    ptr_next       = ptr_reg;
    hold_cnt_next  = hold_cnt_reg;
    timeout_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|req_i) begin
          state_next     = ST_GRANTED;
          grant_idx_next = rr_pick(req_i, ptr_reg);
          hold_cnt_next  = '0;
        end
      end
      ST_GRANTED: begin
        hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        if (grant_done) begin
          state_next   = ST_IDLE;
          ptr_next     = (grant_idx_reg == IDX_LAST) ? '0 : grant_idx_reg + IDX_W'(1);
          // Flag the revocation only when the timer was the sole reason.
          timeout_next = hold_expired && !release_i && owner_req;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= ST_IDLE;
      grant_idx_reg <= '0;
      ptr_reg       <= '0;
      hold_cnt_reg  <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_idx_reg <= grant_idx_next;
      ptr_reg       <= ptr_next;
      hold_cnt_reg  <= hold_cnt_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign grant_valid_o = (state_reg == ST_GRANTED);
  assign grant_idx_o   = grant_idx_reg;
  assign timeout_o     = timeout_reg;
  assign grant_o       = idx_one_hot & {NUM_REQ{grant_valid_o}};

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a behavioural model.
module tb_rr_onehot_arbiter;

  localparam int NR = 16;
  localparam int MH = 8;
  localparam int FAIR_BOUND = NR * (MH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NR-1:0] req_drv = '0;
  logic          rel_drv = 1'b0;
  logic [NR-1:0] grant_o;
  logic [3:0]    grant_idx_o;
  logic          grant_valid_o;
  logic          timeout_o;

  int errors = 0;
  int checks = 0;
  bit verbose = 1'b1;

  // Model state: owner, cycles owned so far, next priority position.
  bit m_valid = 1'b0;
  int m_idx = 0;
  int m_ptr = 0;
  int m_held = 0;
  bit m_timeout = 1'b0;

  int wait_cnt [NR];
  int max_wait = 0;

  rr_onehot_arbiter #(
    .NUM_REQ  (NR),
    .IDX_W    (4),
    .MAX_HOLD (MH),
    .HOLD_W   (8)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .req_i         (req_drv),
    .release_i     (rel_drv),
    .grant_o       (grant_o),
    .grant_idx_o   (grant_idx_o),
    .grant_valid_o (grant_valid_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural model: circular scan from the pointer, grant ends on
  // release, dropped request, or after MH owned cycles.
  always @(posedge clk or negedge rst_n) begin
    bit nv, nt;
    int ni, np, nh;
    if (!rst_n) begin
      m_valid   <= 1'b0;
      m_idx     <= 0;
      m_ptr     <= 0;
      m_held    <= 0;
      m_timeout <= 1'b0;
    end else begin
      nv = m_valid; ni = m_idx; np = m_ptr; nh = m_held; nt = 1'b0;
      if (!m_valid) begin
        for (int i = 0; i < NR; i++) begin
          if (req_drv[(m_ptr + i) % NR]) begin
            ni = (m_ptr + i) % NR;
            nv = 1'b1;
            nh = 1;
            break;
          end
        end
      end else begin
        bit by_rel, by_drop, by_time;
        by_rel  = rel_drv;
        by_drop = !req_drv[m_idx];
        by_time = (MH != 0) && (m_held == MH);
        if (by_rel || by_drop || by_time) begin
          nv = 1'b0;
          np = (m_idx + 1) % NR;
          nt = by_time && !by_rel && !by_drop;
        end else begin
          nh = m_held + 1;
        end
      end
      m_valid   <= nv;
      m_idx     <= ni;
      m_ptr     <= np;
      m_held    <= nh;
      m_timeout <= nt;
    end
  end

  // Per-cycle comparison and fairness tracking.
  always @(negedge clk) begin
    logic [NR-1:0] exp_grant;
    exp_grant = '0;
    if (m_valid) exp_grant[m_idx] = 1'b1;
    check("model_grant_o", 32'(grant_o), 32'(exp_grant));
    check("model_grant_valid_o", 32'(grant_valid_o), 32'(m_valid));
    check("model_grant_idx_o", 32'(grant_idx_o), 32'(m_idx));
    check("model_timeout_o", 32'(timeout_o), 32'(m_timeout));
    if (verbose && m_valid && m_held == 1)
      $display("grant idx=%0d req=%04h t=%0t", m_idx, req_drv, $time);
    for (int k = 0; k < NR; k++) begin
      if (rst_n && req_drv[k] && !grant_o[k]) wait_cnt[k]++;
      else wait_cnt[k] = 0;
      if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
    end
  end

  initial begin
    logic [NR-1:0] rr_exp [4];
    for (int k = 0; k < NR; k++) wait_cnt[k] = 0;
    rr_exp[0] = 16'h0001; rr_exp[1] = 16'h0010; rr_exp[2] = 16'h0001; rr_exp[3] = 16'h0010;

    // Reset and idle.
    #1 rst_n = 1'b0;
    #2;
    check("rst_grant_o", 32'(grant_o), 32'h0);
    check("rst_grant_idx_o", 32'(grant_idx_o), 32'h0);
    check("rst_grant_valid_o", 32'(grant_valid_o), 32'h0);
    check("rst_timeout_o", 32'(timeout_o), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(10);
    $display("idle: 10 cycles no request");
    check("idle_valid", 32'(grant_valid_o), 32'h0);
    check("idle_grant_o", 32'(grant_o), 32'h0);

    // Alternating grants with release on the 3rd owned cycle.
    req_drv = 16'h0011;
    for (int g = 0; g < 4; g++) begin
      step(1);
      check("rr_grant_o", 32'(grant_o), 32'(rr_exp[g]));
      step(2);
      rel_drv = 1'b1;
      step(1);
      rel_drv = 1'b0;
      check("rr_gap_valid", 32'(grant_valid_o), 32'h0);
    end

    // Timeout after exactly MH cycles, regrant one cycle later.
    req_drv = 16'h0004;
    for (int i = 0; i < MH; i++) begin
      step(1);
      check("hold_owner_idx2", 32'(grant_valid_o && grant_idx_o == 4'd2), 32'h1);
    end
    step(1);
    check("tmo_valid_low", 32'(grant_valid_o), 32'h0);
    check("tmo_pulse", 32'(timeout_o), 32'h1);
    step(1);
    check("tmo_regrant_idx", 32'(grant_idx_o), 32'h2);
    check("tmo_regrant_valid", 32'(grant_valid_o), 32'h1);
    check("tmo_pulse_end", 32'(timeout_o), 32'h0);

    // Release coinciding with the last allowed cycle: no timeout flag.
    step(MH - 1);
    check("coinc_still_owned", 32'(grant_valid_o), 32'h1);
    rel_drv = 1'b1;
    step(1);
    rel_drv = 1'b0;
    check("coinc_valid_low", 32'(grant_valid_o), 32'h0);
    check("coinc_no_timeout", 32'(timeout_o), 32'h0);
    req_drv = '0;
    step(1);
    check("coinc_idle", 32'(grant_valid_o), 32'h0);

    // Wrap-around from 15 to 0 and back to 15.
    req_drv = 16'h8000;
    step(1);
    check("wrap_idx15", 32'(grant_idx_o), 32'hf);
    rel_drv = 1'b1;
    req_drv = 16'h8001;
    step(1);
    rel_drv = 1'b0;
    check("wrap_gap", 32'(grant_valid_o), 32'h0);
    step(1);
    check("wrap_grant0", 32'(grant_o), 32'h0001);
    rel_drv = 1'b1;
    step(1);
    rel_drv = 1'b0;
    step(1);
    check("wrap_grant15", 32'(grant_o), 32'h8000);

    // Move the pointer to 4, grant 7, then reset mid-grant.
    req_drv = 16'h0008;
    rel_drv = 1'b1;
    step(1);
    rel_drv = 1'b0;
    step(1);
    check("pre_rst_idx3", 32'(grant_idx_o), 32'h3);
    rel_drv = 1'b1;
    req_drv = 16'h0080;
    step(1);
    rel_drv = 1'b0;
    step(1);
    check("pre_rst_idx7", 32'(grant_idx_o), 32'h7);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_grant_o", 32'(grant_o), 32'h0);
    check("midrst_valid", 32'(grant_valid_o), 32'h0);
    req_drv = 16'h0081;
    step(1);
    rst_n = 1'b1;
    step(1);
    check("postrst_idx0", 32'(grant_idx_o), 32'h0);
    check("postrst_grant_o", 32'(grant_o), 32'h0001);

    // Randomized traffic: slowly changing requests, random releases.
    verbose = 1'b0;
    $display("random: 3000 cycles");
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NR; k++)
        if ($urandom_range(15) == 0) req_drv[k] = ~req_drv[k];
      rel_drv = ($urandom_range(4) == 0);
      step(1);
    end
    check("fairness_bound", 32'(max_wait <= FAIR_BOUND), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
